// File: rtl/sa_cache.sv
// sa_cache: 4-way set-associative, write-back, write-allocate data cache.
// There is one word per line. The design has two states. In IDLE it
// services whatever address is presented. In MISS it waits for the refill.
module sa_cache #(
  parameter int TAG_W    = 18,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 6,
  parameter int DATA_W   = 32,
  parameter int WAYS     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [TAG_W-1:0]                  i_tag,
  input  logic [INDEX_W-1:0]                i_index,
  input  logic [OFFSET_W-1:0]               i_offset,
  input  logic [DATA_W-1:0]                 dataW,
  input  logic                              memRW,
  input  logic [DATA_W-1:0]                 i_memory_line,
  input  logic                              i_memory_response,
  output logic [DATA_W-1:0]                 o_data,
  output logic [DATA_W-1:0]                 line_data,
  output logic                              cache_miss,
  output logic [DATA_W-1:0]                 o_evict_data,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] o_evict_addr,
  output logic                              o_evict
);

  localparam int SETS = 1 << INDEX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t state;

  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [1:0]        age_q   [SETS][WAYS];

  logic       hit;
  logic [1:0] hit_way;
  logic       found_invalid;
  logic [1:0] victim_way;
  logic [1:0] victim_q;
  logic [1:0] acc_way;
  logic [1:0] new_age [WAYS];

  // The offset only selects bytes within a line. Lines hold a single word,
  // so the offset never takes part in the lookup.
  logic unused_offset;
  assign unused_offset = ^i_offset;

  // Find the way that holds the requested tag in the addressed set, if any.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[i_index][w] && (tag_q[i_index][w] == i_tag)) begin
        hit     = 1'b1;
        hit_way = 2'(w);
      end
    end
  end

  // Choose a victim. The lowest-numbered invalid way is preferred.
  // Otherwise the least-recently-used way (age 3) is taken.
  always_comb begin
    found_invalid = 1'b0;
    victim_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_invalid && !valid_q[i_index][w]) begin
        found_invalid = 1'b1;
        victim_way    = 2'(w);
      end
    end
    if (!found_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[i_index][w] == 2'd3) victim_way = 2'(w);
      end
    end
  end

  // Compute the ages after a true-LRU touch of the accessed way.
  // The accessed way becomes MRU. Every way that was younger than it ages by one.
  always_comb begin
    acc_way = (state == IDLE) ? hit_way : victim_q;
    for (int w = 0; w < WAYS; w++) begin
      new_age[w] = age_q[i_index][w];
      if (2'(w) == acc_way)
        new_age[w] = 2'd0;
      else if (age_q[i_index][w] < age_q[i_index][acc_way])
        new_age[w] = age_q[i_index][w] + 2'd1;
    end
  end

  // line_data exposes the contents of the hit way. It is valid only during an IDLE lookup.
  assign line_data = (state == IDLE && hit) ? data_q[i_index][hit_way] : '0;

  // Main controller: lookup, miss handling, refill, eviction reporting and reset.
  always_ff @(posedge clk) begin
    o_evict <= 1'b0;
    if (rst) begin
      state        <= IDLE;
      o_data       <= '0;
      cache_miss   <= 1'b0;
      o_evict      <= 1'b0;
      o_evict_data <= '0;
      o_evict_addr <= '0;
      victim_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= 2'(w);
      end
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (memRW) begin
              data_q[i_index][hit_way]  <= dataW;
              dirty_q[i_index][hit_way] <= 1'b1;
              o_data                    <= dataW;
            end else begin
              o_data <= data_q[i_index][hit_way];
            end
            for (int w = 0; w < WAYS; w++) age_q[i_index][w] <= new_age[w];
          end else begin
            victim_q   <= victim_way;
            state      <= MISS;
            cache_miss <= 1'b1;
            if (valid_q[i_index][victim_way] && dirty_q[i_index][victim_way]) begin
              o_evict      <= 1'b1;
              o_evict_data <= data_q[i_index][victim_way];
              o_evict_addr <= {tag_q[i_index][victim_way], i_index, {OFFSET_W{1'b0}}};
            end
          end
        end
        MISS: begin
          if (i_memory_response) begin
            tag_q[i_index][victim_q]   <= i_tag;
            valid_q[i_index][victim_q] <= 1'b1;
            if (memRW) begin
              data_q[i_index][victim_q]  <= dataW;
              dirty_q[i_index][victim_q] <= 1'b1;
              o_data                     <= dataW;
            end else begin
              data_q[i_index][victim_q]  <= i_memory_line;
              dirty_q[i_index][victim_q] <= 1'b0;
              o_data                     <= i_memory_line;
            end
            for (int w = 0; w < WAYS; w++) age_q[i_index][w] <= new_age[w];
            cache_miss <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed stimulus with a queue-based scoreboard for sa_cache.
// Stimulus pushes expected hit, refill and eviction results into queues.
// A negedge monitor pops and compares each entry when the DUT presents the matching output.
module tb_sa_cache;

  logic        clk;
  logic        rst;
  logic [17:0] i_tag;
  logic [7:0]  i_index;
  logic [5:0]  i_offset;
  logic [31:0] dataW;
  logic        memRW;
  logic [31:0] i_memory_line;
  logic        i_memory_response;
  logic [31:0] o_data;
  logic [31:0] line_data;
  logic        cache_miss;
  logic [31:0] o_evict_data;
  logic [31:0] o_evict_addr;
  logic        o_evict;

  sa_cache dut (
    .clk               (clk),
    .rst               (rst),
    .i_tag             (i_tag),
    .i_index           (i_index),
    .i_offset          (i_offset),
    .dataW             (dataW),
    .memRW             (memRW),
    .i_memory_line     (i_memory_line),
    .i_memory_response (i_memory_response),
    .o_data            (o_data),
    .line_data         (line_data),
    .cache_miss        (cache_miss),
    .o_evict_data      (o_evict_data),
    .o_evict_addr      (o_evict_addr),
    .o_evict           (o_evict)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] line;
    logic [31:0] odata;
  } hit_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
  } evict_t;

  hit_t        hit_q[$];
  logic [31:0] miss_q[$];
  evict_t      evict_q[$];

  int checks   = 0;
  int failures = 0;

  logic        chk_hit   = 1'b0;
  logic        chk_reset = 1'b0;
  logic        pend_valid = 1'b0;
  logic [31:0] pend_odata = '0;
  logic        prev_miss  = 1'b0;

  // Compare one value and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive one request onto the CPU port
  task automatic applyStimulus(input logic [17:0] tag, input logic [7:0] idx,
                               input logic rw, input logic [31:0] wdata);
    i_tag    = tag;
    i_index  = idx;
    i_offset = 6'(tag);
    memRW    = rw;
    dataW    = wdata;
  endtask

  // Issue a request that must hit
  task automatic doHit(input logic [17:0] tag, input logic [7:0] idx, input logic rw,
                       input logic [31:0] wdata, input logic [31:0] line, input logic [31:0] odata);
    hit_t e;
    applyStimulus(tag, idx, rw, wdata);
    e.line  = line;
    e.odata = odata;
    hit_q.push_back(e);
    chk_hit = 1'b1;
    @(posedge clk); #1;
    chk_hit = 1'b0;
  endtask

  // Spend one extra cycle in MISS, then return the refill line
  task automatic finishMiss(input logic [31:0] line);
    @(posedge clk); #1;
    i_memory_line     = line;
    i_memory_response = 1'b1;
    @(posedge clk); #1;
    i_memory_response = 1'b0;
  endtask

  // Issue a request that must miss and be refilled
  task automatic doMiss(input logic [17:0] tag, input logic [7:0] idx, input logic rw,
                        input logic [31:0] wdata, input logic [31:0] line, input logic [31:0] odata);
    applyStimulus(tag, idx, rw, wdata);
    miss_q.push_back(odata);
    @(posedge clk); #1;
    finishMiss(line);
  endtask

  // Queue one expected dirty eviction
  task automatic expectEvict(input logic [31:0] data, input logic [31:0] addr);
    evict_t e;
    e.data = data;
    e.addr = addr;
    evict_q.push_back(e);
  endtask

  // Monitor: sample away from the active edge and consume scoreboard entries
  always @(negedge clk) begin
    hit_t   h;
    evict_t ev;
    if (pend_valid) begin
      checkOutput("hit_o_data", o_data, pend_odata);
      checkOutput("hit_cache_miss", {31'b0, cache_miss}, 32'd0);
      pend_valid = 1'b0;
    end
    if (chk_hit) begin
      checkOutput("hit_entry_present", {31'b0, hit_q.size() != 0}, 32'd1);
      if (hit_q.size() != 0) begin
        h = hit_q.pop_front();
        checkOutput("hit_line_data", line_data, h.line);
        pend_odata = h.odata;
        pend_valid = 1'b1;
      end
    end
    if (chk_reset) begin
      checkOutput("reset_o_data", o_data, 32'd0);
      checkOutput("reset_cache_miss", {31'b0, cache_miss}, 32'd0);
      checkOutput("reset_o_evict", {31'b0, o_evict}, 32'd0);
      checkOutput("reset_evict_data", o_evict_data, 32'd0);
      checkOutput("reset_evict_addr", o_evict_addr, 32'd0);
      checkOutput("reset_line_data", line_data, 32'd0);
    end
    if (o_evict) begin
      checkOutput("evict_expected", {31'b0, evict_q.size() != 0}, 32'd1);
      if (evict_q.size() != 0) begin
        ev = evict_q.pop_front();
        checkOutput("evict_data", o_evict_data, ev.data);
        checkOutput("evict_addr", o_evict_addr, ev.addr);
      end
    end
    if (cache_miss && !prev_miss)
      checkOutput("miss_expected", {31'b0, miss_q.size() != 0}, 32'd1);
    if (!cache_miss && prev_miss) begin
      checkOutput("refill_entry_present", {31'b0, miss_q.size() != 0}, 32'd1);
      if (miss_q.size() != 0) checkOutput("refill_o_data", o_data, miss_q.pop_front());
    end
    prev_miss = cache_miss;
  end

  // Directed test sequence
  initial begin
    rst = 1'b1;
    i_memory_response = 1'b0;
    i_memory_line = '0;
    applyStimulus(18'h0, 8'h00, 1'b0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state, followed by a cold miss at tag 0, set 0
    chk_reset = 1'b1;
    miss_q.push_back(32'h0000_0A0A);
    @(posedge clk); #1;
    chk_reset = 1'b0;
    finishMiss(32'h0000_0A0A);

    // Refill, then hit. After that, a write hit and a read-back.
    doMiss(18'h1, 8'h05, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    doHit (18'h1, 8'h05, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    doHit (18'h1, 8'h05, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678);
    doHit (18'h1, 8'h05, 1'b0, 32'h0, 32'h1234_5678, 32'h1234_5678);

    // Fill set 5. Tag 1 is then LRU and dirty, so tag 5 evicts it.
    doMiss(18'h2, 8'h05, 1'b0, 32'h0, 32'h2222_0002, 32'h2222_0002);
    doMiss(18'h3, 8'h05, 1'b0, 32'h0, 32'h3333_0003, 32'h3333_0003);
    doMiss(18'h4, 8'h05, 1'b0, 32'h0, 32'h4444_0004, 32'h4444_0004);
    expectEvict(32'h1234_5678, 32'h0000_4140);
    doMiss(18'h5, 8'h05, 1'b0, 32'h0, 32'h5555_0005, 32'h5555_0005);

    // Touching tag 2 makes tag 3 the clean LRU victim, so there is no eviction pulse.
    doHit (18'h2, 8'h05, 1'b0, 32'h0, 32'h2222_0002, 32'h2222_0002);
    doMiss(18'h6, 8'h05, 1'b0, 32'h0, 32'h6666_0006, 32'h6666_0006);
    doHit (18'h2, 8'h05, 1'b0, 32'h0, 32'h2222_0002, 32'h2222_0002);
    doHit (18'h4, 8'h05, 1'b0, 32'h0, 32'h4444_0004, 32'h4444_0004);
    doHit (18'h5, 8'h05, 1'b0, 32'h0, 32'h5555_0005, 32'h5555_0005);

    // A write miss allocates the line and installs the write data, not the memory line.
    doMiss(18'h7, 8'h09, 1'b1, 32'hCAFE_F00D, 32'h7777_0007, 32'hCAFE_F00D);
    doHit (18'h7, 8'h09, 1'b0, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Reset arrives during a miss, together with a response. Reset wins and o_data clears.
    applyStimulus(18'h8, 8'h05, 1'b0, 32'h0);
    miss_q.push_back(32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    i_memory_line = 32'hBAD0_BAD0;
    i_memory_response = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    i_memory_response = 1'b0;
    doMiss(18'h8, 8'h05, 1'b0, 32'h0, 32'h8888_0008, 32'h8888_0008);
    doHit (18'h8, 8'h05, 1'b0, 32'h0, 32'h8888_0008, 32'h8888_0008);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("hit_q_drained", hit_q.size(), 32'd0);
    checkOutput("miss_q_drained", miss_q.size(), 32'd0);
    checkOutput("evict_q_drained", evict_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
